// File: rtl/sat_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sat_add_arbiter
// Brief    : Round-robin arbiter sharing one registered signed saturating adder
//            among NREQ requesters; single-entry output register with
//            backpressure. Optional saturation counter: SAT_ADD_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
module sat_add_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_z,
   output logic [IDW-1:0]    out_id,
   output logic              out_ovf,
   output logic              out_unf,
   input  logic              stats_clr,
   output logic [15:0]       sat_cnt
);

   localparam logic [W-1:0] c_max_pos = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] c_min_neg = {1'b1, {(W-1){1'b0}}};

   logic [IDW-1:0] r_ptr;
   logic           r_out_valid;
   logic [W-1:0]   r_out_z;
   logic [IDW-1:0] r_out_id;
   logic           r_out_ovf;
   logic           r_out_unf;

   logic           w_found;
   logic [IDW-1:0] w_gnt;
   logic [W-1:0]   w_a;
   logic [W-1:0]   w_b;
   logic           w_space;
   logic           w_xfer;
   logic [W-1:0]   w_s;
   logic           w_ovf;
   logic           w_unf;
   logic [W-1:0]   w_z;

   // Scan from the lowest priority up so the highest-priority valid index wins last.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_a     = '0;
      w_b     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         int idx;
         idx = int'(r_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req_valid[idx]) begin
            w_found = 1'b1;
            w_gnt   = IDW'(idx);
            w_a     = req_a[idx*W +: W];
            w_b     = req_b[idx*W +: W];
         end
      end
   end

   assign w_space = ~r_out_valid | out_ready;
   assign w_xfer  = ~rst & w_found & w_space;

   always_comb begin
      req_ready = '0;
      if (w_xfer) req_ready[w_gnt] = 1'b1;
   end

   assign w_s   = w_a + w_b;
   assign w_ovf = ~w_a[W-1] & ~w_b[W-1] &  w_s[W-1];
   assign w_unf =  w_a[W-1] &  w_b[W-1] & ~w_s[W-1];
   assign w_z   = w_ovf ? c_max_pos : (w_unf ? c_min_neg : w_s);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_xfer) begin
         r_ptr <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_z     <= '0;
         r_out_id    <= '0;
         r_out_ovf   <= 1'b0;
         r_out_unf   <= 1'b0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_z     <= w_z;
         r_out_id    <= w_gnt;
         r_out_ovf   <= w_ovf;
         r_out_unf   <= w_unf;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_z     = r_out_z;
   assign out_id    = r_out_id;
   assign out_ovf   = r_out_ovf;
   assign out_unf   = r_out_unf;

`ifdef SAT_ADD_ARB_STATS_EN
   logic [15:0] r_sat_cnt;

   // Clear beats a coincident increment; the count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         r_sat_cnt <= '0;
      end else if (w_xfer && (w_ovf || w_unf) && (r_sat_cnt != 16'hFFFF)) begin
         r_sat_cnt <= r_sat_cnt + 16'd1;
      end
   end

   assign sat_cnt = r_sat_cnt;
`else
   logic w_unused_stats_clr;
   assign w_unused_stats_clr = stats_clr;
   assign sat_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sat_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sat_add_arbiter
// Brief    : Directed self-checking bench for sat_add_arbiter (NREQ=4, W=8).
// Revision : 1.0
// ============================================================================
module tb_sat_add_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_z;
   logic [1:0]        out_id;
   logic              out_ovf;
   logic              out_unf;
   logic              stats_clr;
   logic [15:0]       sat_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_sat = 0;

   sat_add_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_z     (out_z),
      .out_id    (out_id),
      .out_ovf   (out_ovf),
      .out_unf   (out_unf),
      .stats_clr (stats_clr),
      .sat_cnt   (sat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   task automatic check_out(input string tag, input logic [1:0] id, input logic [7:0] z,
                            input logic ovf, input logic unf);
      check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_val({tag, "_id"}, 32'(out_id), 32'(id));
      check_val({tag, "_z"}, 32'(out_z), 32'(z));
      check_val({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
      check_val({tag, "_unf"}, 32'(out_unf), 32'(unf));
   endtask

   // a, b, saturated z, ovf, unf for the statistics run on requester 0
   logic [7:0] sa [8] = '{8'h7F, 8'h80, 8'h01, 8'h64, 8'hFF, 8'h9C, 8'h3F, 8'h40};
   logic [7:0] sb [8] = '{8'h01, 8'hFF, 8'h01, 8'h64, 8'h01, 8'h9C, 8'h40, 8'h40};
   logic [7:0] sz [8] = '{8'h7F, 8'h80, 8'h02, 8'h7F, 8'h00, 8'h80, 8'h7F, 8'h7F};
   logic       so [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic       su [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [7:0] exp_z   [5] = '{8'd17, 8'd34, 8'd51, 8'd68, 8'd17};
      rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0;
      out_ready = 1'b1; stats_clr = 1'b0;

      // reset state
      tick();
      check_val("rst_ready", 32'(req_ready), 32'd0);
      tick();
      check_val("rst_valid", 32'(out_valid), 32'd0);
      check_val("rst_z", 32'(out_z), 32'd0);
      check_val("rst_id", 32'(out_id), 32'd0);
      check_val("rst_flags", 32'({out_ovf, out_unf}), 32'd0);
      check_val("rst_sat", 32'(sat_cnt), 32'd0);

      // all requesting: rotation 0,1,2,3,0 with results one cycle later
      for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i + 1), 8'(16 * (i + 1)));
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check_val("rr_ready", 32'(req_ready), 32'(exp_gnt[k]));
         tick();
         check_out("rr_out", exp_id[k], exp_z[k], 1'b0, 1'b0);
      end

      // requester 2 alone: overflow, underflow, mixed-sign no clip
      req_valid = 4'b0100;
      set_ops(2, 8'd100, 8'd50);
      tick();
      check_out("ovf", 2'd2, 8'h7F, 1'b1, 1'b0);
      set_ops(2, 8'h9C, 8'hCE);
      tick();
      check_out("unf", 2'd2, 8'h80, 1'b0, 1'b1);
      set_ops(2, 8'h80, 8'h7F);
      tick();
      check_out("mix", 2'd2, 8'hFF, 1'b0, 1'b0);
      exp_sat += 2;
      req_valid = 4'b0000;
      tick();
      check_val("drain_valid", 32'(out_valid), 32'd0);

      // stall: pending result holds, no grants, pointer frozen at 1
      req_valid = 4'b0001;
      set_ops(0, 8'd1, 8'd2);
      tick();
      check_out("pend", 2'd0, 8'd3, 1'b0, 1'b0);
      out_ready = 1'b0; req_valid = 4'b1111;
      set_ops(1, 8'd5, 8'd6);
      for (int k = 0; k < 3; k++) begin
         #1;
         check_val("stall_ready", 32'(req_ready), 32'd0);
         tick();
         check_out("stall_out", 2'd0, 8'd3, 1'b0, 1'b0);
      end
      out_ready = 1'b1;
      #1;
      check_val("release_ready", 32'(req_ready), 32'b0010);
      tick();
      check_out("release_out", 2'd1, 8'd11, 1'b0, 1'b0);

      // 1 and 3 valid with pointer at 2
      req_valid = 4'b1010;
      #1;
      check_val("p2_ready", 32'(req_ready), 32'b1000);
      tick();
      check_out("p2_out3", 2'd3, 8'd68, 1'b0, 1'b0);
      #1;
      check_val("p0_ready", 32'(req_ready), 32'b0010);
      tick();
      check_out("p0_out1", 2'd1, 8'd11, 1'b0, 1'b0);

      // request dropped before acceptance leaves nothing behind
      req_valid = 4'b0001; out_ready = 1'b0;
      tick();
      check_out("drop_hold", 2'd1, 8'd11, 1'b0, 1'b0);
      req_valid = 4'b0000; out_ready = 1'b1;
      tick();
      check_val("drop_valid", 32'(out_valid), 32'd0);

      // reset with a stalled pending result
      req_valid = 4'b0100;
      tick();
      check_out("prerst", 2'd2, 8'hFF, 1'b0, 1'b0);
      out_ready = 1'b0; rst = 1'b1; req_valid = 4'b1111;
      #1;
      check_val("midrst_ready", 32'(req_ready), 32'd0);
      tick();
      check_val("midrst_valid", 32'(out_valid), 32'd0);
      check_val("midrst_z", 32'(out_z), 32'd0);
      check_val("midrst_id", 32'(out_id), 32'd0);
      exp_sat = 0;
      rst = 1'b0; req_valid = 4'b0110; out_ready = 1'b1;
      #1;
      check_val("postrst_ready", 32'(req_ready), 32'b0010);
      tick();
      check_out("postrst_out", 2'd1, 8'd11, 1'b0, 1'b0);

      // saturation statistics on requester 0
      req_valid = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         set_ops(0, sa[k], sb[k]);
         tick();
         check_out("st_op", 2'd0, sz[k], so[k], su[k]);
         if (so[k] || su[k]) exp_sat++;
      end
`ifdef SAT_ADD_ARB_STATS_EN
      check_val("sat_cnt5", 32'(sat_cnt), 32'(exp_sat));
`else
      check_val("sat_cnt5", 32'(sat_cnt), 32'd0);
`endif
      set_ops(0, 8'h7F, 8'h7F); stats_clr = 1'b1;
      tick();
      check_out("clr_op", 2'd0, 8'h7F, 1'b1, 1'b0);
      check_val("sat_clr", 32'(sat_cnt), 32'd0);
      set_ops(0, 8'h80, 8'h80); stats_clr = 1'b0;
      tick();
      check_out("after_clr_op", 2'd0, 8'h80, 1'b0, 1'b1);
`ifdef SAT_ADD_ARB_STATS_EN
      check_val("sat_after_clr", 32'(sat_cnt), 32'd1);
`else
      check_val("sat_after_clr", 32'(sat_cnt), 32'd0);
`endif
      req_valid = 4'b0000;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
